// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: word-aligned PC, 2-entry in-order fetch queue,
// redirect with kill counting of in-flight responses.
// Optional feature macro FETCH_PERF_CNT_EN adds perf_bubble_cnt_o.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  fetch_unit_if.master imem,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt_o
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = 2;
  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] pc_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] kill_q;
  logic            wr_ptr_q;
  logic            fill_ptr_q;
  logic            rd_ptr_q;
  logic [DEPTH-1:0] filled_q;
  logic [XLEN-1:0] ent_pc_q    [DEPTH];
  logic [XLEN-1:0] ent_instr_q [DEPTH];

  logic            req;
  logic            grant;
  logic            xfer;
  logic            fill;
  logic            kill_dec;
  logic [CNTW-1:0] n_filled;
  logic [CNTW-1:0] unfilled;
  logic [CNTW:0]   inflight;
  logic            rvalid_old;
  logic [CNTW-1:0] kill_redir;

  // Occupancy, request gating and response classification
  always_comb begin
    n_filled   = CNTW'(filled_q[0]) + CNTW'(filled_q[1]);
    unfilled   = count_q - n_filled;
    inflight   = (CNTW+1)'(count_q) + (CNTW+1)'(kill_q);
    req        = rst_ni & ~redirect_i & (inflight < (CNTW+1)'(2));
    grant      = req & imem.imem_gnt_i;
    xfer       = id_valid_o & id_ready_i;
    fill       = ~redirect_i & imem.imem_rvalid_i & (kill_q == '0) & (unfilled != '0);
    kill_dec   = ~redirect_i & imem.imem_rvalid_i & (kill_q != '0);
    // a response landing in the redirect cycle retires one old-stream slot
    rvalid_old = imem.imem_rvalid_i & ((kill_q != '0) | (unfilled != '0));
    kill_redir = kill_q + unfilled - CNTW'(rvalid_old);
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  // Decode-side view comes straight from the queue head registers
  assign id_valid_o = filled_q[rd_ptr_q];
  assign id_instr_o = ent_instr_q[rd_ptr_q];
  assign id_pc_o    = ent_pc_q[rd_ptr_q];

  // PC, queue and kill-counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC_AL;
      count_q    <= '0;
      kill_q     <= '0;
      wr_ptr_q   <= 1'b0;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      filled_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
      count_q    <= '0;
      kill_q     <= kill_redir;
      wr_ptr_q   <= 1'b0;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      filled_q   <= '0;
    end else begin
      if (grant) begin
        ent_pc_q[wr_ptr_q] <= pc_q;
        wr_ptr_q           <= ~wr_ptr_q;
        pc_q               <= pc_q + XLEN'(4);
      end
      if (fill) begin
        ent_instr_q[fill_ptr_q] <= imem.imem_rdata_i;
        filled_q[fill_ptr_q]    <= 1'b1;
        fill_ptr_q              <= ~fill_ptr_q;
      end
      if (kill_dec) begin
        kill_q <= kill_q - CNTW'(1);
      end
      if (xfer) begin
        filled_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= ~rd_ptr_q;
      end
      count_q <= count_q + CNTW'(grant) - CNTW'(xfer);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic            redir_d_q;
  logic [XLEN-1:0] perf_cnt_q;

  // Saturating count of decode-starved cycles, ignoring redirect shadow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redir_d_q  <= 1'b0;
      perf_cnt_q <= '0;
    end else begin
      redir_d_q <= redirect_i;
      if (id_ready_i && !id_valid_o && !redirect_i && !redir_d_q && (perf_cnt_q != '1)) begin
        perf_cnt_q <= perf_cnt_q + XLEN'(1);
      end
    end
  end

  assign perf_bubble_cnt_o = perf_cnt_q;
`endif

endmodule
